// File: rtl/icache_refill_ctrl.sv
// rtl/icache_refill_ctrl.sv - fetch-stage I-cache miss controller and block refill sequencer
module icache_refill_ctrl #(
  parameter int BLOCK_WORDS = 4,
  parameter int OFFSET_BITS = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [31:0]                    pc,
  input  logic                           cache_hit,
  output logic                           pc_write,
  output logic                           if_id_hit,
  output logic                           mem_req,
  output logic [31:0]                    mem_addr,
  input  logic                           mem_ack,
  input  logic                           mem_rvalid,
  input  logic [31:0]                    mem_rdata,
  output logic                           refill_we,
  output logic [$clog2(BLOCK_WORDS)-1:0] refill_word,
  output logic [31:0]                    refill_data,
  output logic                           refill_tag_we,
  output logic [31:0]                    refill_addr,
  output logic                           busy,
  output logic [15:0]                    miss_count
);

  localparam int WORD_BITS = $clog2(BLOCK_WORDS);
  localparam logic [WORD_BITS-1:0] LAST_BEAT = WORD_BITS'(BLOCK_WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_FILL = 2'd2,
    S_TAG  = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [WORD_BITS-1:0]  r_beat;
  logic [31:0]           r_refill_addr;
  logic [15:0]           r_miss_count;
  logic [31:0]           w_block_addr;
  logic                  w_unused_pc_offset;

  // Block-aligned address of the current fetch; the offset bits only select a word inside the block.
  assign w_block_addr       = {pc[31:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
  assign w_unused_pc_offset = ^pc[OFFSET_BITS-1:0];

  assign refill_addr = r_refill_addr;
  assign miss_count  = r_miss_count;
  assign busy        = (r_state != S_IDLE);

  // State register, beat counter, latched miss address and saturating miss counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_beat        <= '0;
      r_refill_addr <= '0;
      r_miss_count  <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (!cache_hit) begin
            r_refill_addr <= w_block_addr;
            if (r_miss_count != 16'hFFFF) begin
              r_miss_count <= r_miss_count + 16'd1;
            end
          end
        end
        S_REQ: begin
          if (mem_ack) begin
            r_beat <= '0;
          end
        end
        S_FILL: begin
          if (mem_rvalid) begin
            r_beat <= r_beat + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Next-state and per-state outputs; fetch follows the hit only while idle.
  always_comb begin
    w_next        = r_state;
    pc_write      = 1'b0;
    if_id_hit     = 1'b0;
    mem_req       = 1'b0;
    mem_addr      = '0;
    refill_we     = 1'b0;
    refill_word   = '0;
    refill_data   = '0;
    refill_tag_we = 1'b0;
    case (r_state)
      S_IDLE: begin
        pc_write  = cache_hit;
        if_id_hit = cache_hit;
        if (!cache_hit) begin
          w_next = S_REQ;
        end
      end
      S_REQ: begin
        // A beat arriving together with the ack is dropped: data may only follow the ack.
        mem_req  = 1'b1;
        mem_addr = r_refill_addr;
        if (mem_ack) begin
          w_next = S_FILL;
        end
      end
      S_FILL: begin
        if (mem_rvalid) begin
          refill_we   = 1'b1;
          refill_word = r_beat;
          refill_data = mem_rdata;
          if (r_beat == LAST_BEAT) begin
            w_next = S_TAG;
          end
        end
      end
      S_TAG: begin
        refill_tag_we = 1'b1;
        w_next        = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// tb/tb_icache_refill_ctrl.sv - self-checking bench for icache_refill_ctrl
module tb_icache_refill_ctrl;

  localparam int BW = 4;
  localparam int OB = 4;

  logic        clk;
  logic        rst_n;
  logic [31:0] pc;
  logic        cache_hit;
  logic        pc_write;
  logic        if_id_hit;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        refill_we;
  logic [1:0]  refill_word;
  logic [31:0] refill_data;
  logic        refill_tag_we;
  logic [31:0] refill_addr;
  logic        busy;
  logic [15:0] miss_count;

  int n_checks;
  int n_pass;
  int exp_misses;

  icache_refill_ctrl #(.BLOCK_WORDS(BW), .OFFSET_BITS(OB)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pc            (pc),
    .cache_hit     (cache_hit),
    .pc_write      (pc_write),
    .if_id_hit     (if_id_hit),
    .mem_req       (mem_req),
    .mem_addr      (mem_addr),
    .mem_ack       (mem_ack),
    .mem_rvalid    (mem_rvalid),
    .mem_rdata     (mem_rdata),
    .refill_we     (refill_we),
    .refill_word   (refill_word),
    .refill_data   (refill_data),
    .refill_tag_we (refill_tag_we),
    .refill_addr   (refill_addr),
    .busy          (busy),
    .miss_count    (miss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #6000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic [31:0] pc;
    int          ack_d;
    logic [31:0] pat;
    logic [31:0] dbase;
    bit          rv_req;
    bit          replay;
    logic [31:0] exp_addr;
    int          exp_stall;
  } vec_t;

  vec_t vecs[5];

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  function automatic int fill_cycles(input logic [31:0] pat);
    logic [31:0] sh;
    int beats;
    int cyc;
    sh = pat;
    beats = 0;
    cyc = 0;
    while (beats < BW) begin
      cyc++;
      if (sh[0]) beats++;
      sh = {1'b1, sh[31:1]};
    end
    return cyc;
  endfunction

  task automatic note_miss();
    if (exp_misses < 65535) exp_misses++;
  endtask

  // One complete miss: IDLE miss cycle, REQ with ack delay, FILL with gap pattern (LSB first), TAG.
  task automatic do_miss(input logic [31:0] p, input int ack_d, input logic [31:0] pat,
                         input logic [31:0] dbase, input bit rv_in_req,
                         input logic [31:0] exp_addr, output int stall);
    logic [31:0] sh;
    int k;
    logic rv;
    stall = 0;
    pc = p;
    cache_hit = 1'b0;
    mem_ack = 1'b0;
    mem_rvalid = 1'b0;
    @(negedge clk);
    chk1("miss_pc_write", pc_write, 1'b0);
    chk1("miss_if_id_hit", if_id_hit, 1'b0);
    chk1("miss_busy", busy, 1'b0);
    @(posedge clk); #1;
    note_miss();
    for (int d = 0; d <= ack_d; d++) begin
      pc = $urandom;
      cache_hit = 1'($urandom);
      mem_ack = (d == ack_d);
      mem_rvalid = rv_in_req;
      mem_rdata = $urandom;
      @(negedge clk);
      chk1("req_mem_req", mem_req, 1'b1);
      chk32("req_mem_addr", mem_addr, exp_addr);
      chk1("req_refill_we", refill_we, 1'b0);
      chk1("req_busy", busy, 1'b1);
      chk1("req_if_id_hit", if_id_hit, 1'b0);
      if (pc_write == 1'b0) stall++;
      @(posedge clk); #1;
    end
    mem_ack = 1'b0;
    sh = pat;
    k = 0;
    while (k < BW) begin
      rv = sh[0];
      sh = {1'b1, sh[31:1]};
      mem_rvalid = rv;
      mem_rdata = dbase + 32'(k);
      pc = $urandom;
      cache_hit = 1'($urandom);
      @(negedge clk);
      chk1("fill_we", refill_we, rv);
      if (rv) begin
        chk32("fill_word", 32'(refill_word), 32'(k));
        chk32("fill_data", refill_data, dbase + 32'(k));
      end
      chk1("fill_mem_req", mem_req, 1'b0);
      chk1("fill_tag_we", refill_tag_we, 1'b0);
      chk32("fill_refill_addr", refill_addr, exp_addr);
      if (pc_write == 1'b0) stall++;
      @(posedge clk); #1;
      if (rv) k++;
    end
    mem_rvalid = 1'b0;
    pc = $urandom;
    cache_hit = 1'($urandom);
    @(negedge clk);
    chk1("tag_we", refill_tag_we, 1'b1);
    chk1("tag_refill_we", refill_we, 1'b0);
    chk1("tag_busy", busy, 1'b1);
    chk32("tag_refill_addr", refill_addr, exp_addr);
    if (pc_write == 1'b0) stall++;
    @(posedge clk); #1;
  endtask

  // A hit cycle in IDLE: fetch advances and the miss count is visible.
  task automatic hit_cycle(input logic [31:0] p);
    pc = p;
    cache_hit = 1'b1;
    @(negedge clk);
    chk1("hit_pc_write", pc_write, 1'b1);
    chk1("hit_if_id_hit", if_id_hit, 1'b1);
    chk1("hit_busy", busy, 1'b0);
    chk1("hit_tag_we", refill_tag_we, 1'b0);
    chk32("hit_miss_count", 32'(miss_count), 32'(exp_misses));
    @(posedge clk); #1;
  endtask

  initial begin
    int st;
    n_checks = 0;
    n_pass = 0;
    exp_misses = 0;

    vecs[0] = '{32'h0000_1238, 0, 32'hFFFF_FFFF, 32'h0000_00A0, 1'b0, 1'b1, 32'h0000_1230, 6};
    vecs[1] = '{32'h4000_0104, 3, 32'hFFFF_FFED, 32'h0000_00B0, 1'b0, 1'b1, 32'h4000_0100, 11};
    vecs[2] = '{32'h0000_0010, 2, 32'hFFFF_FFFF, 32'h0000_00C0, 1'b1, 1'b1, 32'h0000_0010, 8};
    vecs[3] = '{32'h8000_000F, 1, 32'hFFFF_FFFE, 32'h0000_00D0, 1'b0, 1'b0, 32'h8000_0000, 8};
    vecs[4] = '{32'hFFFF_FFFC, 0, 32'hFFFF_FFFF, 32'h0000_00E0, 1'b0, 1'b1, 32'hFFFF_FFF0, 6};

    rst_n = 1'b0;
    pc = 32'h0;
    cache_hit = 1'b1;
    mem_ack = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata = 32'h0;
    @(posedge clk); #1;
    chk1("rst_mem_req", mem_req, 1'b0);
    chk1("rst_refill_we", refill_we, 1'b0);
    chk1("rst_tag_we", refill_tag_we, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk32("rst_miss_count", 32'(miss_count), 32'h0);
    chk32("rst_refill_addr", refill_addr, 32'h0);
    chk1("rst_pc_write", pc_write, 1'b1);
    chk1("rst_if_id_hit", if_id_hit, 1'b1);
    cache_hit = 1'b0;
    #1;
    chk1("rst_pc_write_mirror", pc_write, 1'b0);
    chk1("rst_busy_on_miss", busy, 1'b0);
    cache_hit = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    hit_cycle(32'h0000_0100);

    for (int i = 0; i < 5; i++) begin
      do_miss(vecs[i].pc, vecs[i].ack_d, vecs[i].pat, vecs[i].dbase, vecs[i].rv_req,
              vecs[i].exp_addr, st);
      chk32("vec_stall", 32'(st), 32'(vecs[i].exp_stall));
      if (vecs[i].replay) hit_cycle(vecs[i].pc);
    end

    pc = 32'h0000_2004;
    cache_hit = 1'b0;
    @(posedge clk); #1;
    note_miss();
    mem_ack = 1'b1;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata = 32'h0000_0011;
    @(negedge clk);
    chk32("midrst_word0", 32'(refill_word), 32'd0);
    @(posedge clk); #1;
    mem_rdata = 32'h0000_0012;
    @(negedge clk);
    chk32("midrst_word1", 32'(refill_word), 32'd1);
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk1("midrst_busy", busy, 1'b0);
    chk1("midrst_mem_req", mem_req, 1'b0);
    chk1("midrst_tag_we", refill_tag_we, 1'b0);
    chk32("midrst_miss_count", 32'(miss_count), 32'h0);
    chk32("midrst_refill_addr", refill_addr, 32'h0);
    chk1("midrst_pc_write", pc_write, 1'b0);
    cache_hit = 1'b1;
    @(negedge clk);
    chk1("midrst_tag_we_hold", refill_tag_we, 1'b0);
    chk1("midrst_pc_write_hit", pc_write, 1'b1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_misses = 0;
    do_miss(32'h0000_2004, 0, 32'hFFFF_FFFF, 32'h0000_0050, 1'b0, 32'h0000_2000, st);
    chk32("midrst_restart_stall", 32'(st), 32'd6);
    hit_cycle(32'h0000_2004);

    for (int n = 0; n < 40; n++) begin
      logic [31:0] rp;
      logic [31:0] rpat;
      int ad;
      int nh;
      rp = $urandom;
      rpat = $urandom | $urandom;
      ad = $urandom_range(0, 4);
      do_miss(rp, ad, rpat, $urandom, 1'($urandom), (rp >> OB) << OB, st);
      chk32("rand_stall", 32'(st), 32'(ad + 1 + fill_cycles(rpat) + 1));
      nh = $urandom_range(0, 2);
      for (int h = 0; h < nh; h++) hit_cycle($urandom);
    end

    @(posedge clk); #1;
    rst_n = 1'b0;
    pc = 32'h0000_3000;
    cache_hit = 1'b0;
    mem_ack = 1'b1;
    mem_rvalid = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (7 * 65534) @(posedge clk);
    @(negedge clk);
    chk32("sat_before", 32'(miss_count), 32'h0000_FFFE);
    chk1("sat_before_idle", busy, 1'b0);
    repeat (7) @(posedge clk);
    @(negedge clk);
    chk32("sat_reach", 32'(miss_count), 32'h0000_FFFF);
    repeat (14) @(posedge clk);
    @(negedge clk);
    chk32("sat_hold", 32'(miss_count), 32'h0000_FFFF);
    chk1("sat_hold_idle", busy, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
